eth_rx_pkt_filter: RTL and testbench
====================================

Name: eth_rx_pkt_filter

Overview:
- Store-and-forward receive buffer between the 10G MAC receive AXI-Stream master (no tready) and the eth_encap receive slave, in the clk156 domain.
- Fully buffers each frame and releases it downstream only after its tlast beat arrives clean (tuser=0).
- Drops errored frames and frames that overflow the buffer, so downstream logic never sees a partial or bad frame.
- Downstream side has a tready handshake; tie it to 1 when the consumer is always ready.

Parameters:
- DATA_WIDTH, 64, AXIS data width in bits.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- DEPTH, 512, buffer depth in beats; power of two, minimum 4.
- ADDR_W, $clog2(DEPTH), buffer address width.

Ports:
- clk156  input  1  156.25 MHz Ethernet core clock.
- eth_rst_n  input  1  synchronous active-low reset.
- s_axis_tvalid  input  1  MAC rx beat valid; no backpressure.
- s_axis_tdata  input  DATA_WIDTH  MAC rx data.
- s_axis_tkeep  input  KEEP_WIDTH  MAC rx byte enables.
- s_axis_tlast  input  1  last beat of frame.
- s_axis_tuser  input  1  frame error; meaningful only on the tlast beat.
- m_axis_tvalid  output  1  output beat valid.
- m_axis_tready  input  1  downstream ready.
- m_axis_tdata  output  DATA_WIDTH  output data.
- m_axis_tkeep  output  KEEP_WIDTH  output byte enables.
- m_axis_tlast  output  1  output last beat.
- m_axis_tuser  output  1  constant 0; bad frames never leave the block.
- frame_pass_cnt  output  32  frames committed.
- frame_err_cnt  output  32  frames dropped for tuser=1.
- frame_ovf_cnt  output  32  frames dropped for overflow.

Behaviour:
- Reset (eth_rst_n=0 at posedge clk156): all pointers cleared; write FSM to IDLE; m_axis_tvalid, tlast, tuser, tdata, tkeep = 0; all counters = 0.
- Reset mid-frame discards the buffer contents. The first beat after reset is treated as a frame start.
- Storage: DEPTH entries of {tlast, tkeep, tdata}.
- Pointers: wr_ptr, commit_ptr, rd_ptr, each ADDR_W+1 bits and wrapping naturally.
- used = wr_ptr - rd_ptr. Full when used == DEPTH.
- Write FSM states: IDLE, WRITE, DROP.
  - IDLE + beat: if not full, store the beat and go to WRITE; else go to DROP.
  - WRITE + beat, not full: store the beat and advance wr_ptr.
  - WRITE + beat, full: wr_ptr <= commit_ptr, go to DROP. If that beat has tlast, increment frame_ovf_cnt and go to IDLE instead.
  - tlast beat stored, tuser=0: commit_ptr <= wr_ptr+1, increment frame_pass_cnt, go to IDLE.
  - tlast beat stored, tuser=1: wr_ptr <= commit_ptr, increment frame_err_cnt, go to IDLE.
  - DROP: ignore beats until tlast, then increment frame_ovf_cnt and go to IDLE. tuser is ignored while in DROP.
  - A single-beat frame (tlast on the first beat) follows the same rules directly from IDLE.
  - A frame longer than DEPTH beats is always dropped as overflow.
- Read side:
  - Data is available when rd_ptr != commit_ptr.
  - Synchronous RAM read with a 1-entry output register: pop when the output register is empty, or when m_axis_tvalid && m_axis_tready.
  - Output data holds stable while tvalid=1 and tready=0.
  - Latency: a committed frame's first beat is on m_axis_tvalid 2 cycles after the tlast input cycle.
  - Full throughput: one beat per cycle while tready=1.
- Simultaneous events:
  - A commit and a pop in the same cycle are both honoured.
  - The full check uses the rd_ptr from before the same-cycle pop, which is conservative.
  - Rewinding wr_ptr never moves it below commit_ptr; rd_ptr is never affected by a drop.
- Counters are 32-bit and wrap modulo 2^32.
- Counter updates occur in the cycle after the tlast beat and are visible one cycle later.

Optional Feature:
- Macro: ETH_RX_PKT_FILTER_STATS_EN.
- Defined: the three counters are implemented as specified.
- Undefined: no counter registers are built, and the three counter outputs are constant 0.
- Datapath behaviour is identical in both cases.

Test Plan:
- Clean frame: 8 beats, tuser=0, last tkeep=8'h0F, tready=1 → identical 8 beats out; first beat 2 cycles after input tlast; m_axis_tuser=0; frame_pass_cnt=1.
- Errored frame: 6 beats, tuser=1 on tlast, followed by a 4-beat clean frame → only the 4-beat frame appears; frame_err_cnt=1, frame_pass_cnt=1.
- Overflow: DEPTH=16, tready=0, send a 10-beat frame then a 10-beat frame → first is kept and the second is dropped (frame_ovf_cnt=1). Raising tready then yields exactly the 10 beats of the first frame.
- Backpressure: toggle tready with pattern 1,0,0,1 during a 12-beat frame → no beat lost or duplicated; data stable while stalled.
- Back-to-back: 100 single-beat and 64-beat frames with no idle cycles, tready=1 → all delivered in order; frame_pass_cnt=100.
- Reset mid-frame: assert eth_rst_n=0 for 1 cycle after beat 3 of 8 → m_axis_tvalid=0 next cycle; counters 0; the next clean frame passes unchanged.

Source files
------------

// File: rtl/eth_rx_pkt_filter.sv
// eth_rx_pkt_filter: store-and-forward MAC rx buffer; only clean, complete frames leave.
// Optional frame counters are built when ETH_RX_PKT_FILTER_STATS_EN is defined.
module eth_rx_pkt_filter #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH      = 512,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk156,
  input  logic                  eth_rst_n,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic [31:0]           frame_pass_cnt,
  output logic [31:0]           frame_err_cnt,
  output logic [31:0]           frame_ovf_cnt
);

  localparam int ENT_W = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

  state_t           state;
  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  commit_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic [ADDR_W:0]  used;
  logic             full;
  logic             wr_en;
  logic             fin_pass;
  logic             fin_err;
  logic             rewind;
  logic             pop;
  logic [ENT_W-1:0] mem [DEPTH];

  // Full is judged against the pre-pop rd_ptr, so it may be pessimistic by one beat.
  always_comb begin
    used     = wr_ptr - rd_ptr;
    full     = (used == FULL_LVL);
    wr_en    = s_axis_tvalid && (state != DROP) && !full;
    fin_pass = wr_en && s_axis_tlast && !s_axis_tuser;
    fin_err  = wr_en && s_axis_tlast && s_axis_tuser;
    rewind   = fin_err || (s_axis_tvalid && (state != DROP) && full);
    pop      = (rd_ptr != commit_ptr) && (!m_axis_tvalid || m_axis_tready);
  end

  always_ff @(posedge clk156) begin
    if (!eth_rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
    end else begin
      if (fin_pass) begin
        wr_ptr     <= wr_ptr + 1'b1;
        commit_ptr <= wr_ptr + 1'b1;
      end else if (rewind) begin
        wr_ptr <= commit_ptr;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (s_axis_tvalid) begin
        if (s_axis_tlast)
          state <= IDLE;
        else if (wr_en)
          state <= WRITE;
        else
          state <= DROP;
      end
    end
  end

  always_ff @(posedge clk156) begin
    if (wr_en)
      mem[wr_ptr[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  end

  // RAM read lands directly in the output register.
  always_ff @(posedge clk156) begin
    if (!eth_rst_n) begin
      rd_ptr        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tkeep  <= '0;
      m_axis_tdata  <= '0;
    end else if (pop) begin
      rd_ptr        <= rd_ptr + 1'b1;
      m_axis_tvalid <= 1'b1;
      {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= mem[rd_ptr[ADDR_W-1:0]];
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  assign m_axis_tuser = 1'b0;

`ifdef ETH_RX_PKT_FILTER_STATS_EN
  logic        fin_ovf;
  logic        pass_evt;
  logic        err_evt;
  logic        ovf_evt;
  logic [31:0] pass_cnt;
  logic [31:0] err_cnt;
  logic [31:0] ovf_cnt;

  assign fin_ovf = s_axis_tvalid && s_axis_tlast
                && ((state == DROP) || full);

  always_ff @(posedge clk156) begin
    if (!eth_rst_n) begin
      pass_evt <= 1'b0;
      err_evt  <= 1'b0;
      ovf_evt  <= 1'b0;
      pass_cnt <= '0;
      err_cnt  <= '0;
      ovf_cnt  <= '0;
    end else begin
      pass_evt <= fin_pass;
      err_evt  <= fin_err;
      ovf_evt  <= fin_ovf;
      pass_cnt <= pass_cnt + {31'd0, pass_evt};
      err_cnt  <= err_cnt + {31'd0, err_evt};
      ovf_cnt  <= ovf_cnt + {31'd0, ovf_evt};
    end
  end

  assign frame_pass_cnt = pass_cnt;
  assign frame_err_cnt  = err_cnt;
  assign frame_ovf_cnt  = ovf_cnt;
`else
  assign frame_pass_cnt = 32'd0;
  assign frame_err_cnt  = 32'd0;
  assign frame_ovf_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_eth_rx_pkt_filter.sv
// tb_eth_rx_pkt_filter: directed frames through a 16-deep and a 128-deep instance.
// Counter expectations follow ETH_RX_PKT_FILTER_STATS_EN.
`timescale 1ns/1ps
module tb_eth_rx_pkt_filter;

`ifdef ETH_RX_PKT_FILTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk156 = 1'b0;
  logic        eth_rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [63:0] s_data = '0;
  logic [7:0]  s_keep = '0;
  logic        s_last = 1'b0;
  logic        s_user = 1'b0;
  logic        ready_lvl = 1'b1;
  logic        bp_mode = 1'b0;
  logic        bp_ready = 1'b1;
  logic [1:0]  bp_idx = '0;
  logic [3:0]  pat = 4'b1001;
  logic        use_l = 1'b0;
  wire         m_ready = bp_mode ? bp_ready : ready_lvl;

  logic        sv, sl, su, lv, ll, lu;
  logic [63:0] sd, ld;
  logic [7:0]  sk, lk;
  logic [31:0] sp, se, so, lp, le, lo;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int t_last = 0;
  int first_v = -1;
  logic        held_v = 1'b0;
  logic [79:0] held = '0;
  logic [79:0] got_q[$];
  logic [79:0] exp_q[$];

  eth_rx_pkt_filter #(.DATA_WIDTH(64), .DEPTH(16)) dut_s (
    .clk156(clk156), .eth_rst_n(eth_rst_n),
    .s_axis_tvalid(s_valid), .s_axis_tdata(s_data),
    .s_axis_tkeep(s_keep), .s_axis_tlast(s_last),
    .s_axis_tuser(s_user),
    .m_axis_tvalid(sv), .m_axis_tready(m_ready),
    .m_axis_tdata(sd), .m_axis_tkeep(sk),
    .m_axis_tlast(sl), .m_axis_tuser(su),
    .frame_pass_cnt(sp), .frame_err_cnt(se),
    .frame_ovf_cnt(so)
  );

  eth_rx_pkt_filter #(.DATA_WIDTH(64), .DEPTH(128)) dut_l (
    .clk156(clk156), .eth_rst_n(eth_rst_n),
    .s_axis_tvalid(s_valid), .s_axis_tdata(s_data),
    .s_axis_tkeep(s_keep), .s_axis_tlast(s_last),
    .s_axis_tuser(s_user),
    .m_axis_tvalid(lv), .m_axis_tready(m_ready),
    .m_axis_tdata(ld), .m_axis_tkeep(lk),
    .m_axis_tlast(ll), .m_axis_tuser(lu),
    .frame_pass_cnt(lp), .frame_err_cnt(le),
    .frame_ovf_cnt(lo)
  );

  wire        o_valid = use_l ? lv : sv;
  wire [63:0] o_data  = use_l ? ld : sd;
  wire [7:0]  o_keep  = use_l ? lk : sk;
  wire        o_last  = use_l ? ll : sl;
  wire        o_user  = use_l ? lu : su;
  wire [31:0] o_pass  = use_l ? lp : sp;
  wire [31:0] o_errc  = use_l ? le : se;
  wire [31:0] o_ovf   = use_l ? lo : so;
  wire [79:0] o_beat  = {6'd0, o_user, o_last, o_keep, o_data};

  always #5 clk156 = ~clk156;

  always @(posedge clk156) cyc++;

  task automatic check(input string tag, input logic [79:0] got,
                       input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cexp(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  // Beats are taken on the negedge preceding the edge that consumes them.
  always @(negedge clk156) begin
    if (eth_rst_n) begin
      if (o_valid && m_ready) got_q.push_back(o_beat);
      if (first_v < 0 && o_valid) first_v = cyc;
      if (held_v) check("stall_hold", {o_valid, o_beat[78:0]}, {1'b1, held[78:0]});
      held_v = o_valid && !m_ready;
      held   = o_beat;
    end else begin
      held_v = 1'b0;
    end
  end

  always @(posedge clk156) begin
    if (bp_mode) begin
      #1;
      bp_ready = pat[bp_idx];
      bp_idx   = bp_idx + 2'd1;
    end
  end

  task automatic do_reset();
    @(posedge clk156); #1;
    eth_rst_n = 1'b0;
    s_valid   = 1'b0;
    @(posedge clk156); #1;
    eth_rst_n = 1'b1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic beat(input logic [63:0] d, input logic [7:0] k,
                      input logic l, input logic u);
    s_valid = 1'b1;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    s_user  = u;
    if (l) t_last = cyc;
    @(posedge clk156); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_user  = 1'b0;
  endtask

  task automatic frame(input int n, input logic [63:0] base,
                       input logic [7:0] lk_in, input logic u,
                       input logic keep_it);
    logic       l;
    logic [7:0] k;
    for (int i = 0; i < n; i++) begin
      l = (i == n - 1);
      k = l ? lk_in : 8'hFF;
      beat(base + 64'(i), k, l, u);
      if (keep_it) exp_q.push_back({6'd0, 1'b0, l, k, base + 64'(i)});
    end
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while (got_q.size() < exp_q.size() && t < budget) begin
      @(posedge clk156);
      t++;
    end
    repeat (6) @(posedge clk156);
    #1;
    check("beat_count", 80'(got_q.size()), 80'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("beat", got_q[i], exp_q[i]);
  endtask

  task automatic chk_cnt(input int p, input int e, input int o);
    check("pass_cnt", 80'(o_pass), 80'(cexp(p)));
    check("err_cnt", 80'(o_errc), 80'(cexp(e)));
    check("ovf_cnt", 80'(o_ovf), 80'(cexp(o)));
  endtask

  initial begin
    repeat (3) @(posedge clk156);
    #1;
    eth_rst_n = 1'b1;
    @(negedge clk156);
    check("rst_tvalid", 80'(o_valid), 80'd0);
    check("rst_tdata", 80'(o_data), 80'd0);
    check("rst_tkeep", 80'(o_keep), 80'd0);
    check("rst_tlast", 80'(o_last), 80'd0);
    check("rst_tuser", 80'(o_user), 80'd0);
    check("rst_pass", 80'(o_pass), 80'd0);
    check("rst_err", 80'(o_errc), 80'd0);
    check("rst_ovf", 80'(o_ovf), 80'd0);
    @(posedge clk156); #1;

    // clean 8-beat frame
    do_reset();
    first_v = -1;
    frame(8, 64'hA5A5_0000_0000_0000, 8'h0F, 1'b0, 1'b1);
    drain(50);
    check("latency", 80'(first_v - t_last), 80'd2);
    chk_cnt(1, 0, 0);

    // errored frame then clean frame
    do_reset();
    frame(6, 64'hBAD0_0000_0000_0000, 8'hFF, 1'b1, 1'b0);
    frame(4, 64'h4444_0000_0000_0010, 8'h07, 1'b0, 1'b1);
    drain(50);
    chk_cnt(1, 1, 0);

    // overflow while stalled
    do_reset();
    ready_lvl = 1'b0;
    frame(10, 64'h1111_0000_0000_0100, 8'h3F, 1'b0, 1'b1);
    frame(10, 64'h2222_0000_0000_0200, 8'hFF, 1'b0, 1'b0);
    repeat (4) @(posedge clk156);
    @(negedge clk156);
    check("ovf_head_valid", 80'(o_valid), 80'd1);
    check("ovf_head_data", 80'(o_data), 80'(64'h1111_0000_0000_0100));
    check("ovf_no_beats", 80'(got_q.size()), 80'd0);
    chk_cnt(1, 0, 1);
    @(posedge clk156); #1;
    ready_lvl = 1'b1;
    drain(60);

    // backpressure 1,0,0,1
    do_reset();
    bp_idx   = '0;
    bp_ready = 1'b1;
    bp_mode  = 1'b1;
    frame(12, 64'h3333_0000_0000_0300, 8'h01, 1'b0, 1'b1);
    drain(100);
    bp_mode = 1'b0;
    chk_cnt(1, 0, 0);

    // back-to-back single-beat and 64-beat frames
    use_l = 1'b1;
    do_reset();
    for (int f = 0; f < 100; f++) begin
      if (f % 2 == 0)
        frame(1, {8'hC0, 8'(f), 48'h0}, 8'h80, 1'b0, 1'b1);
      else
        frame(64, {8'hD0, 8'(f), 48'h0}, 8'hFF, 1'b0, 1'b1);
    end
    drain(400);
    chk_cnt(100, 0, 0);
    use_l = 1'b0;

    // reset in the middle of a frame
    do_reset();
    ready_lvl = 1'b0;
    frame(3, 64'h5555_0000_0000_0500, 8'hFF, 1'b0, 1'b0);
    repeat (3) @(posedge clk156);
    @(negedge clk156);
    check("pre_rst_valid", 80'(o_valid), 80'd1);
    @(posedge clk156); #1;
    for (int i = 0; i < 3; i++)
      beat(64'h6666_0000_0000_0600 + 64'(i), 8'hFF, 1'b0, 1'b0);
    eth_rst_n = 1'b0;
    @(posedge clk156); #1;
    eth_rst_n = 1'b1;
    @(negedge clk156);
    check("mid_rst_valid", 80'(o_valid), 80'd0);
    check("mid_rst_pass", 80'(o_pass), 80'd0);
    check("mid_rst_err", 80'(o_errc), 80'd0);
    check("mid_rst_ovf", 80'(o_ovf), 80'd0);
    @(posedge clk156); #1;
    got_q.delete();
    exp_q.delete();
    ready_lvl = 1'b1;
    frame(8, 64'h7777_0000_0000_0700, 8'h1F, 1'b0, 1'b1);
    drain(50);
    chk_cnt(1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
